// File: rtl/snoop_responder_pkg.sv
// -----------------------------------------------------------------------------
// snoop_responder_pkg
//   Types and constants shared by the MSI coherence bus and the per-CPU snoop
//   responder: address/data widths, MSI block-state encodings, the responder
//   FSM state type and the snoop kind (read search vs. invalidate).
// -----------------------------------------------------------------------------
package snoop_responder_pkg;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 16;

  localparam logic [1:0] BLOCK_STATE_MODIFIED = 2'b10;
  localparam logic [1:0] BLOCK_STATE_SHARED   = 2'b01;
  localparam logic [1:0] BLOCK_STATE_INVALID  = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd1,
    WB   = 2'd2,
    UPD  = 2'd3
  } snoop_st_t;

  typedef enum logic {
    RD  = 1'b0,
    INV = 1'b1
  } snoop_kind_t;

  // 2'b11 is not a legal MSI state and is treated like Invalid.
  function automatic logic state_is_valid(input logic [1:0] st);
    return (st == BLOCK_STATE_MODIFIED) || (st == BLOCK_STATE_SHARED);
  endfunction

endpackage

// File: rtl/snoop_responder_if.sv
// -----------------------------------------------------------------------------
// snoop_responder_if
//   Bundles every signal between the snoop responder and its surroundings
//   (bus commands, tag/state/data array, dmem write-back port, results).
//   Parameter: INDEX_W - cache index width; tag width is 13-INDEX_W.
//   Modports:
//     slave  - the responder (consumes commands, array read data, wb_ack)
//     master - the environment (bus, tag array, dmem)
// -----------------------------------------------------------------------------
interface snoop_responder_if #(
  parameter int INDEX_W = 3
) ();
  import snoop_responder_pkg::*;

  logic                       snoop_search;
  logic                       snoop_inv;
  logic [ADDR_W-1:0]          snoop_addr;
  logic [INDEX_W-1:0]         tag_idx;
  logic [ADDR_W-INDEX_W-1:0]  tag_rd_tag;
  logic [1:0]                 tag_rd_state;
  logic [DATA_W-1:0]          tag_rd_data;
  logic                       st_we;
  logic [INDEX_W-1:0]         st_idx;
  logic [1:0]                 st_new;
  logic                       search_found;
  logic [1:0]                 block_state;
  logic [DATA_W-1:0]          fwd_data;
  logic                       wb_req;
  logic [ADDR_W-1:0]          wb_addr;
  logic [DATA_W-1:0]          wb_data;
  logic                       wb_ack;
  logic                       busy;

  modport slave (
    input  snoop_search, snoop_inv, snoop_addr,
    input  tag_rd_tag, tag_rd_state, tag_rd_data, wb_ack,
    output tag_idx, st_we, st_idx, st_new,
    output search_found, block_state, fwd_data,
    output wb_req, wb_addr, wb_data, busy
  );

  modport master (
    output snoop_search, snoop_inv, snoop_addr,
    output tag_rd_tag, tag_rd_state, tag_rd_data, wb_ack,
    input  tag_idx, st_we, st_idx, st_new,
    input  search_found, block_state, fwd_data,
    input  wb_req, wb_addr, wb_data, busy
  );

endinterface

// File: rtl/snoop_tag_match.sv
// -----------------------------------------------------------------------------
// snoop_tag_match
//   Combinational lookup for a direct-mapped cache: splits the snoop address
//   into index/tag and qualifies the stored tag and MSI state into a hit.
//   Ports:
//     addr      in   13-bit word address
//     rd_tag    in   stored tag at idx
//     rd_state  in   stored MSI state at idx
//     idx       out  array read index (addr low bits)
//     hit       out  tag equal and state is M or S
//     hit_state out  stored state on a hit, Invalid on a miss
// -----------------------------------------------------------------------------
module snoop_tag_match
  import snoop_responder_pkg::*;
#(
  parameter int INDEX_W = 3
) (
  input  logic [ADDR_W-1:0]         addr,
  input  logic [ADDR_W-INDEX_W-1:0] rd_tag,
  input  logic [1:0]                rd_state,
  output logic [INDEX_W-1:0]        idx,
  output logic                      hit,
  output logic [1:0]                hit_state
);

  assign idx       = addr[INDEX_W-1:0];
  assign hit       = (rd_tag == addr[ADDR_W-1:INDEX_W]) && state_is_valid(rd_state);
  assign hit_state = hit ? rd_state : BLOCK_STATE_INVALID;

endmodule

// File: rtl/snoop_responder.sv
// -----------------------------------------------------------------------------
// snoop_responder
//   Cache-side responder for the two-CPU MSI bus. Answers snoop searches
//   (hit/state/data forwarding, write-back of Modified lines, M->S downgrade)
//   and cross-invalidates (->I) against the local direct-mapped data cache.
//   Parameters:
//     INDEX_W  - cache index bits
//     FWD_HOLD - cycles the search result is held valid (>=1)
//   Ports:
//     clk  - system clock
//     rst  - synchronous active-high reset
//     bus  - snoop_responder_if.slave (commands, array port, write-back, results)
//   Build option:
//     SNOOP_WB_ON_INV_EN - when defined, an invalidate hitting a Modified line
//     writes it back before marking it Invalid; otherwise the data is dropped.
// -----------------------------------------------------------------------------
module snoop_responder
  import snoop_responder_pkg::*;
#(
  parameter int INDEX_W  = 3,
  parameter int FWD_HOLD = 2
) (
  input logic              clk,
  input logic              rst,
  snoop_responder_if.slave bus
);

  localparam int CNT_W = (FWD_HOLD > 1) ? $clog2(FWD_HOLD) : 1;

  logic [INDEX_W-1:0] lookup_idx;
  logic               lookup_hit;
  logic [1:0]         lookup_state;

  snoop_tag_match #(.INDEX_W(INDEX_W)) u_tag_match (
    .addr      (bus.snoop_addr),
    .rd_tag    (bus.tag_rd_tag),
    .rd_state  (bus.tag_rd_state),
    .idx       (lookup_idx),
    .hit       (lookup_hit),
    .hit_state (lookup_state)
  );

  assign bus.tag_idx = lookup_idx;

  snoop_st_t          state_q,     state_d;
  snoop_kind_t        kind_q,      kind_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic [1:0]         cap_state_q, cap_state_d;  // Invalid when the lookup missed
  logic [ADDR_W-1:0]  cap_addr_q,  cap_addr_d;
  logic [DATA_W-1:0]  cap_data_q,  cap_data_d;
  logic               found_q,     found_d;
  logic [1:0]         blk_q,       blk_d;
  logic [DATA_W-1:0]  fwd_q,       fwd_d;
  logic               wb_req_q,    wb_req_d;
  logic [ADDR_W-1:0]  wb_addr_q,   wb_addr_d;
  logic [DATA_W-1:0]  wb_data_q,   wb_data_d;
  logic               st_we_q,     st_we_d;
  logic [INDEX_W-1:0] st_idx_q,    st_idx_d;
  logic [1:0]         st_new_q,    st_new_d;
  logic               busy_q,      busy_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d     = state_q;
    kind_d      = kind_q;
    cnt_d       = cnt_q;
    cap_state_d = cap_state_q;
    cap_addr_d  = cap_addr_q;
    cap_data_d  = cap_data_q;
    found_d     = found_q;
    blk_d       = blk_q;
    fwd_d       = fwd_q;

    unique case (state_q)
      IDLE: begin
        if (bus.snoop_inv || bus.snoop_search) begin
          // wb_addr is rebuilt from the stored tag; on a hit it equals snoop_addr.
          cap_state_d = lookup_state;
          cap_addr_d  = {bus.tag_rd_tag, lookup_idx};
          cap_data_d  = bus.tag_rd_data;
        end
        if (bus.snoop_inv) begin
          kind_d = INV;
          if (lookup_hit) begin
`ifdef SNOOP_WB_ON_INV_EN
            state_d = (lookup_state == BLOCK_STATE_MODIFIED) ? WB : UPD;
`else
            state_d = UPD;
`endif
          end
        end else if (bus.snoop_search) begin
          kind_d  = RD;
          cnt_d   = CNT_W'(FWD_HOLD - 1);
          found_d = lookup_hit;
          blk_d   = lookup_state;
          fwd_d   = bus.tag_rd_data;
          state_d = RESP;
        end
      end
      RESP: begin
        if (cnt_q == '0) begin
          found_d = 1'b0;
          blk_d   = BLOCK_STATE_INVALID;
          fwd_d   = '0;
          state_d = (cap_state_q == BLOCK_STATE_MODIFIED) ? WB : IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WB: begin
        if (bus.wb_ack) state_d = UPD;
      end
      UPD: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Registered side outputs follow the next state so they line up with it.
    wb_req_d  = (state_d == WB);
    wb_addr_d = wb_req_d ? cap_addr_d : '0;
    wb_data_d = wb_req_d ? cap_data_d : '0;
    st_we_d   = (state_d == UPD);
    st_idx_d  = st_we_d ? cap_addr_d[INDEX_W-1:0] : '0;
    st_new_d  = !st_we_d        ? BLOCK_STATE_INVALID :
                (kind_d == RD)  ? BLOCK_STATE_SHARED  : BLOCK_STATE_INVALID;
    busy_d    = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      kind_q      <= RD;
      cnt_q       <= '0;
      cap_state_q <= '0;
      cap_addr_q  <= '0;
      cap_data_q  <= '0;
      found_q     <= 1'b0;
      blk_q       <= '0;
      fwd_q       <= '0;
      wb_req_q    <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      st_we_q     <= 1'b0;
      st_idx_q    <= '0;
      st_new_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      cnt_q       <= cnt_d;
      cap_state_q <= cap_state_d;
      cap_addr_q  <= cap_addr_d;
      cap_data_q  <= cap_data_d;
      found_q     <= found_d;
      blk_q       <= blk_d;
      fwd_q       <= fwd_d;
      wb_req_q    <= wb_req_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      st_we_q     <= st_we_d;
      st_idx_q    <= st_idx_d;
      st_new_q    <= st_new_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.search_found = found_q;
  assign bus.block_state  = blk_q;
  assign bus.fwd_data     = fwd_q;
  assign bus.wb_req       = wb_req_q;
  assign bus.wb_addr      = wb_addr_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.st_we        = st_we_q;
  assign bus.st_idx       = st_idx_q;
  assign bus.st_new       = st_new_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_snoop_responder.sv
// -----------------------------------------------------------------------------
// tb_snoop_responder
//   Directed bench for snoop_responder (INDEX_W=3, FWD_HOLD=2). A transaction
//   model turns each command into a per-cycle timeline of expected outputs,
//   a negedge process compares the DUT against it every cycle, and each
//   directed vector also pins one hand-computed output record.
//   Honours SNOOP_WB_ON_INV_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_snoop_responder;
  import snoop_responder_pkg::*;

  localparam int IW = 3;
  localparam int H  = 2;

  typedef struct packed {
    logic        busy;
    logic        found;
    logic [1:0]  bst;
    logic [15:0] fwd;
    logic        wb_req;
    logic [12:0] wb_addr;
    logic [15:0] wb_data;
    logic        st_we;
    logic [2:0]  st_idx;
    logic [1:0]  st_new;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   chk_en = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0]  mem_tag   [8];
  logic [1:0]  mem_state [8];
  logic [15:0] mem_data  [8];

  rec_t exp_q[$];

  snoop_responder_if #(.INDEX_W(IW)) bif ();

  snoop_responder #(.INDEX_W(IW), .FWD_HOLD(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  assign bif.tag_rd_tag   = mem_tag[bif.tag_idx];
  assign bif.tag_rd_state = mem_state[bif.tag_idx];
  assign bif.tag_rd_data  = mem_data[bif.tag_idx];

  function automatic rec_t mk(logic busy, logic found, logic [1:0] bst, logic [15:0] fwd,
                              logic wbr, logic [12:0] wba, logic [15:0] wbd,
                              logic we, logic [2:0] sidx, logic [1:0] snew);
    rec_t r;
    r = '{busy, found, bst, fwd, wbr, wba, wbd, we, sidx, snew};
    return r;
  endfunction

  function automatic rec_t dut_rec();
    return mk(bif.busy, bif.search_found, bif.block_state, bif.fwd_data,
              bif.wb_req, bif.wb_addr, bif.wb_data, bif.st_we, bif.st_idx, bif.st_new);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // Transaction model: the outputs the responder must show, cycle by cycle,
  // starting at the cycle the command is presented (cycle 0). Cycles after
  // 'cut' are dropped (reset taken at the end of that cycle).
  task automatic plan(input bit srch, input bit inv, input logic [12:0] addr,
                      input int n_ack, input int cut,
                      output int len, output int ack_cyc);
    rec_t        tl[$];
    int          idx;
    logic [1:0]  st;
    logic [15:0] dat;
    bit          hit, dirty, do_wb;
    idx   = int'(addr[2:0]);
    st    = mem_state[idx];
    dat   = mem_data[idx];
    hit   = (mem_tag[idx] == addr[12:3]) &&
            (st == BLOCK_STATE_MODIFIED || st == BLOCK_STATE_SHARED);
    dirty = hit && (st == BLOCK_STATE_MODIFIED);
    do_wb = 1'b0;
    ack_cyc = -1;
    tl.push_back('0);
    if (inv) begin
      if (hit) begin
`ifdef SNOOP_WB_ON_INV_EN
        do_wb = dirty;
`endif
        if (do_wb) begin
          ack_cyc = 1 + n_ack;
          for (int i = 0; i <= n_ack; i++)
            tl.push_back(mk(1, 0, 0, 0, 1, addr, dat, 0, 0, 0));
        end
        tl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, addr[2:0], BLOCK_STATE_INVALID));
      end
    end else if (srch) begin
      for (int i = 0; i < H; i++)
        tl.push_back(mk(1, hit, hit ? st : 2'b00, dat, 0, 0, 0, 0, 0, 0));
      if (dirty) begin
        ack_cyc = H + 1 + n_ack;
        for (int i = 0; i <= n_ack; i++)
          tl.push_back(mk(1, 0, 0, 0, 1, addr, dat, 0, 0, 0));
        tl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, addr[2:0], BLOCK_STATE_SHARED));
      end
    end
    len = 0;
    foreach (tl[i]) begin
      if (cut < 0 || i <= cut) begin
        exp_q.push_back(tl[i]);
        len++;
      end
    end
  endtask

  // Drive one command, then run through its timeline plus two idle cycles.
  // 'stray' fires search+inv+ack with another address in cycle 1 (must be
  // ignored); 'rst_cyc' pulses reset in that cycle; 'pin' is a literal
  // expectation checked in cycle 'pin_cyc'.
  task automatic run(input string name, input bit srch, input bit inv,
                     input logic [12:0] addr, input int n_ack, input bit stray,
                     input int rst_cyc, input int pin_cyc, input rec_t pin);
    int len, ack_cyc;
    @(posedge clk); #1;
    plan(srch, inv, addr, n_ack, rst_cyc, len, ack_cyc);
    bif.snoop_addr   = addr;
    bif.snoop_search = srch;
    bif.snoop_inv    = inv;
    for (int cyc = 1; cyc < len + 2; cyc++) begin
      @(posedge clk); #1;
      bif.snoop_search = stray && cyc == 1;
      bif.snoop_inv    = stray && cyc == 1;
      if (stray && cyc == 1) bif.snoop_addr = 13'h0005;
      bif.wb_ack = (stray && cyc == 1) || (ack_cyc >= 0 && cyc == ack_cyc);
      rst = (cyc == rst_cyc);
      if (cyc == pin_cyc) check({name, "_pin"}, 64'(dut_rec()), 64'(pin));
    end
  endtask

  // Single compare process against the model timeline (idle when empty).
  always @(negedge clk) begin
    rec_t e;
    if (chk_en) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else                  e = '0;
      check($sformatf("outputs_t%0t", $time), 64'(dut_rec()), 64'(e));
      check("tag_idx", 64'(bif.tag_idx), 64'(bif.snoop_addr[2:0]));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bif.snoop_search = 1'b0;
    bif.snoop_inv    = 1'b0;
    bif.snoop_addr   = '0;
    bif.wb_ack       = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mem_tag[i]   = '0;
      mem_state[i] = BLOCK_STATE_INVALID;
      mem_data[i]  = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_state", 64'(dut_rec()), 64'(rec_t'('0)));
    chk_en = 1'b1;

    // Shared hit: 0x0123 -> index 3, tag 0x024.
    mem_tag[3] = 10'h024; mem_state[3] = BLOCK_STATE_SHARED; mem_data[3] = 16'hBEEF;
    run("search_s_hit", 1, 0, 13'h0123, 0, 0, -1, 1,
        mk(1, 1, 2'b01, 16'hBEEF, 0, 0, 0, 0, 0, 0));

    // Modified hit, ack 3 cycles after wb_req, stray commands during RESP.
    mem_state[3] = BLOCK_STATE_MODIFIED; mem_data[3] = 16'h1234;
    run("search_m_hit", 1, 0, 13'h0123, 3, 1, -1, 3,
        mk(1, 0, 0, 0, 1, 13'h0123, 16'h1234, 0, 0, 0));

    // Tag mismatch at index 3 (tag 0x040): raw data still forwarded.
    run("search_tag_miss", 1, 0, 13'h0203, 0, 0, -1, 2,
        mk(1, 0, 2'b00, 16'h1234, 0, 0, 0, 0, 0, 0));

    // Illegal stored state 11 counts as a miss.
    mem_tag[5] = 10'h010; mem_state[5] = 2'b11; mem_data[5] = 16'h5555;
    run("search_state11", 1, 0, 13'h0085, 0, 0, -1, 1,
        mk(1, 0, 2'b00, 16'h5555, 0, 0, 0, 0, 0, 0));

    // Invalidate and search together on a Shared hit: invalidate wins.
    mem_state[3] = BLOCK_STATE_SHARED; mem_data[3] = 16'hBEEF;
    run("inv_and_search", 1, 1, 13'h0123, 0, 0, -1, 1,
        mk(1, 0, 0, 0, 0, 0, 0, 1, 3'd3, 2'b00));

    // Invalidate on a Modified hit.
    mem_state[3] = BLOCK_STATE_MODIFIED; mem_data[3] = 16'h1234;
`ifdef SNOOP_WB_ON_INV_EN
    run("inv_m_hit", 0, 1, 13'h0123, 1, 0, -1, 1,
        mk(1, 0, 0, 0, 1, 13'h0123, 16'h1234, 0, 0, 0));
`else
    run("inv_m_hit", 0, 1, 13'h0123, 1, 0, -1, 1,
        mk(1, 0, 0, 0, 0, 0, 0, 1, 3'd3, 2'b00));
`endif

    // Invalidate miss: nothing happens.
    run("inv_miss", 0, 1, 13'h0203, 0, 0, -1, 1, rec_t'('0));

    // Modified hit with wb_ack in the very first WB cycle; 0x0AAE -> idx 6.
    mem_tag[6] = 10'h155; mem_state[6] = BLOCK_STATE_MODIFIED; mem_data[6] = 16'hA5A5;
    run("search_m_ack0", 1, 0, 13'h0AAE, 0, 0, -1, 4,
        mk(1, 0, 0, 0, 0, 0, 0, 1, 3'd6, 2'b01));

    // Reset in the second WB cycle: everything clears, no st_we afterwards.
    run("rst_in_wb", 1, 0, 13'h0123, 5, 0, 4, 5, rec_t'('0));

    // New search accepted after the reset; 0x1D51 -> idx 1, tag 0x3AA.
    mem_tag[1] = 10'h3AA; mem_state[1] = BLOCK_STATE_SHARED; mem_data[1] = 16'hCAFE;
    run("search_after_rst", 1, 0, 13'h1D51, 0, 0, -1, 2,
        mk(1, 1, 2'b01, 16'hCAFE, 0, 0, 0, 0, 0, 0));

    @(posedge clk); #1;
    chk_en = 1'b0;
    check("model_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
